// File: rtl/prim_dump_tx_if.sv
// prim_dump_tx_if
//   Bundles the two buses the primitive dumper talks on:
//     - read port into the primitive RAM (mem_rd_en, mem_addr, mem_data),
//       with data returned one cycle after the read enable;
//     - valid/ready byte stream towards the debug transmitter
//       (tx_data, tx_valid, tx_ready, tx_last).
//   master : the dumper (issues reads, drives the byte stream)
//   slave  : the RAM + transmitter side
interface prim_dump_tx_if #(
    parameter int PRIM_ADDR_WIDTH = 8,
    parameter int PRIM_WIDTH      = 216
);
    logic                       mem_rd_en;
    logic [PRIM_ADDR_WIDTH-1:0] mem_addr;
    logic [PRIM_WIDTH-1:0]      mem_data;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       tx_last;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_data,
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_data,
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/prim_dump_tx.sv
// prim_dump_tx
//   Streams packed primitive records out of the primitive RAM as bytes,
//   most significant byte first, for host-side checking / scene round-trips.
//   Walks indices 0..num_prims-1, one RAM read per primitive.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      one-cycle pulse, starts a dump when idle
//   num_prims  primitive count, sampled on an accepted start
//   busy       high from accepted start until done
//   done       one-cycle pulse when the dump completes
//   bus        RAM read port + byte stream (prim_dump_tx_if.master)
module prim_dump_tx #(
    parameter int PRIM_ADDR_WIDTH = 8,
    parameter int FIXED_WIDTH     = 32,
    parameter int COLOR_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PRIM_ADDR_WIDTH:0] num_prims,
    output logic                     busy,
    output logic                     done,
    prim_dump_tx_if.master           bus
);
    // Packed record: Min XYZ, Max XYZ, three colour channels; width is a whole number of bytes.
    localparam int PRIM_WIDTH = 6 * FIXED_WIDTH + 3 * COLOR_WIDTH;
    localparam int PRIM_BYTES = PRIM_WIDTH / 8;
    localparam int CNT_W      = (PRIM_BYTES > 1) ? $clog2(PRIM_BYTES) : 1;

    localparam logic [CNT_W-1:0]         LAST_BYTE = CNT_W'(PRIM_BYTES - 1);
    localparam logic [CNT_W-1:0]         ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0]         ZERO_CNT  = CNT_W'(0);
    localparam logic [PRIM_ADDR_WIDTH:0] ONE_IDX   = {{PRIM_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PRIM_ADDR_WIDTH:0] ZERO_IDX  = {(PRIM_ADDR_WIDTH + 1){1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                     state_r;
    logic [PRIM_ADDR_WIDTH:0]   count_r;
    logic [PRIM_ADDR_WIDTH:0]   idx_r;
    logic [PRIM_WIDTH-1:0]      shift_r;
    logic [CNT_W-1:0]           byte_cnt_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       mem_rd_en_r;
    logic [PRIM_ADDR_WIDTH-1:0] mem_addr_r;
    logic [7:0]                 tx_data_r;
    logic                       tx_valid_r;
    logic                       tx_last_r;

    logic                       handshake_s;
    logic                       last_prim_s;
    logic                       last_byte_s;
    logic [CNT_W-1:0]           next_cnt_s;
    logic [PRIM_ADDR_WIDTH:0]   idx_inc_s;

    // Index compare is one bit wider than the address so a count of 2**PRIM_ADDR_WIDTH does not wrap.
    assign handshake_s = tx_valid_r && bus.tx_ready;
    assign last_prim_s = (idx_r == (count_r - ONE_IDX));
    assign last_byte_s = (byte_cnt_r == LAST_BYTE);
    assign next_cnt_s  = byte_cnt_r + ONE_CNT;
    assign idx_inc_s   = idx_r + ONE_IDX;

    // Dump sequencer: fetch, wait for RAM data, shift bytes out, repeat per primitive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            count_r     <= ZERO_IDX;
            idx_r       <= ZERO_IDX;
            shift_r     <= {PRIM_WIDTH{1'b0}};
            byte_cnt_r  <= ZERO_CNT;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_rd_en_r <= 1'b0;
            mem_addr_r  <= {PRIM_ADDR_WIDTH{1'b0}};
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            tx_last_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        if (num_prims == ZERO_IDX) begin
                            // Empty dump: report completion without touching the RAM.
                            done_r  <= 1'b1;
                            state_r <= S_FIN;
                        end else begin
                            count_r     <= num_prims;
                            idx_r       <= ZERO_IDX;
                            busy_r      <= 1'b1;
                            mem_rd_en_r <= 1'b1;
                            mem_addr_r  <= {PRIM_ADDR_WIDTH{1'b0}};
                            state_r     <= S_FETCH;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    // Read was issued on entry; data lands during WAIT.
                    mem_rd_en_r <= 1'b0;
                    state_r     <= S_WAIT;
                end
                S_WAIT: begin
                    tx_data_r  <= bus.mem_data[PRIM_WIDTH-1 -: 8];
                    shift_r    <= {bus.mem_data[PRIM_WIDTH-9:0], 8'h00};
                    byte_cnt_r <= ZERO_CNT;
                    tx_valid_r <= 1'b1;
                    tx_last_r  <= last_prim_s && (LAST_BYTE == ZERO_CNT);
                    state_r    <= S_SEND;
                end
                S_SEND: begin
                    if (handshake_s) begin
                        if (last_byte_s) begin
                            tx_valid_r <= 1'b0;
                            tx_last_r  <= 1'b0;
                            if (last_prim_s) begin
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= S_FIN;
                            end else begin
                                idx_r       <= idx_inc_s;
                                mem_rd_en_r <= 1'b1;
                                mem_addr_r  <= idx_inc_s[PRIM_ADDR_WIDTH-1:0];
                                state_r     <= S_FETCH;
                            end
                        end else begin
                            // shift_r already excludes the byte on the wire.
                            tx_data_r  <= shift_r[PRIM_WIDTH-1 -: 8];
                            shift_r    <= {shift_r[PRIM_WIDTH-9:0], 8'h00};
                            byte_cnt_r <= next_cnt_s;
                            tx_last_r  <= last_prim_s && (next_cnt_s == LAST_BYTE);
                        end
                    end else begin
                        // Stalled: hold data, last and valid.
                        state_r <= S_SEND;
                    end
                end
                S_FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    mem_rd_en_r <= 1'b0;
                    tx_valid_r  <= 1'b0;
                    tx_last_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign bus.mem_rd_en = mem_rd_en_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_valid  = tx_valid_r;
    assign bus.tx_last   = tx_last_r;
endmodule

// File: tb/tb_prim_dump_tx.sv
// Testbench for prim_dump_tx: RAM model, randomized back-pressure,
// queue-based scoreboard with an independent negedge monitor.
module tb_prim_dump_tx;
    localparam int AW = 8;
    localparam int PW = 216;
    localparam int PB = 27;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_prims;
    logic          busy;
    logic          done;

    prim_dump_tx_if #(.PRIM_ADDR_WIDTH(AW), .PRIM_WIDTH(PW)) bus ();

    prim_dump_tx #(.PRIM_ADDR_WIDTH(AW), .FIXED_WIDTH(32), .COLOR_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_prims (num_prims),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data valid the cycle after the read enable.
    logic [PW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_data <= ram[bus.mem_addr];

    // Back-pressure driver.
    int ready_mode = 0;
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = (ready_mode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    typedef struct { logic [7:0] data; logic last; int cyc; } exp_byte_t;
    typedef struct { logic [AW-1:0] addr; int cyc; } exp_rd_t;
    exp_byte_t bq[$];
    exp_rd_t   rdq[$];
    int        dq[$];   // expected done cycle; -2 = one cycle after the last handshake

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string nm, longint act, longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void unexpected(string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
    endfunction

    // Monitor: compares every DUT event against the queues.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    int         hs_total = 0;
    int         last_hs_cyc = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.tx_valid, 1);
                check("hold_data", bus.tx_data, prev_data);
                check("hold_last", bus.tx_last, prev_last);
            end
            if (bus.tx_valid) begin
                check("busy_during_tx", busy, 1);
                if (bus.tx_ready) begin
                    if (bq.size() == 0) unexpected("tx_byte");
                    else begin
                        exp_byte_t e;
                        e = bq.pop_front();
                        check("tx_data", bus.tx_data, e.data);
                        check("tx_last", bus.tx_last, e.last);
                        if (e.cyc >= 0) check("tx_cycle", cyc, e.cyc);
                    end
                    hs_total++;
                    last_hs_cyc = cyc;
                end
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_last  = bus.tx_last;
            if (bus.mem_rd_en) begin
                if (rdq.size() == 0) unexpected("mem_read");
                else begin
                    exp_rd_t r;
                    r = rdq.pop_front();
                    check("mem_addr", bus.mem_addr, r.addr);
                    if (r.cyc >= 0) check("mem_rd_cycle", cyc, r.cyc);
                end
            end
            if (done) begin
                check("busy_at_done", busy, 0);
                if (dq.size() == 0) unexpected("done");
                else begin
                    int d;
                    d = dq.pop_front();
                    if (d == -2) check("done_cycle", cyc, last_hs_cyc + 1);
                    else check("done_cycle", cyc, d);
                end
            end
        end
    end

    // Reference model: record i is sent as its bytes from most to least significant.
    task automatic run_dump(int n, bit timed);
        int s;
        s = cyc;
        num_prims = n[AW:0];
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            rdq.push_back('{addr: i[AW-1:0], cyc: timed ? s + 1 + i * (PB + 2) : -1});
            for (int b = 0; b < PB; b++)
                bq.push_back('{data: ram[i][PW-1-8*b -: 8], last: (i == n - 1) && (b == PB - 1),
                               cyc: timed ? s + 3 + i * (PB + 2) + b : -1});
        end
        if (n == 0) dq.push_back(s + 1);
        else dq.push_back(timed ? s + 3 + (n - 1) * (PB + 2) + PB : -2);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int k;
        k = 0;
        while ((bq.size() != 0 || rdq.size() != 0 || dq.size() != 0) && k < 20000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 20000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: dump did not complete, %0d bytes outstanding", nm, bq.size());
            bq.delete(); rdq.delete(); dq.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_outputs_zero(string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_rd_en"}, bus.mem_rd_en, 0);
        check({pfx, "_addr"}, bus.mem_addr, 0);
        check({pfx, "_valid"}, bus.tx_valid, 0);
        check({pfx, "_last"}, bus.tx_last, 0);
        check({pfx, "_data"}, bus.tx_data, 0);
    endtask

    task automatic fill_random(int n);
        logic [223:0] t;
        for (int i = 0; i < n; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ram[i] = t[PW-1:0];
        end
    endtask

    initial begin
        int base;
        int k;
        int n;
        reset = 1'b1;
        start = 1'b0;
        num_prims = '0;
        fill_random(1 << AW);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs_zero("reset");

        // Known record, full rate.
        ram[0] = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 8'hFF, 8'h80, 8'h01};
        run_dump(1, 1'b1);
        wait_idle("single");

        // Four records, every byte of record i equal to i.
        for (int i = 0; i < 4; i++) ram[i] = {PB{i[7:0]}};
        run_dump(4, 1'b1);
        wait_idle("four");

        // Random data with 30% ready duty.
        fill_random(2);
        ready_mode = 1;
        run_dump(2, 1'b0);
        wait_idle("backpressure");
        ready_mode = 0;

        // Empty dump.
        run_dump(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("empty_busy", busy, 0);
            @(posedge clk);
            #1;
        end
        wait_idle("empty");

        // Start re-pulsed mid-dump is ignored.
        fill_random(8);
        run_dump(3, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        num_prims = 9'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("repulse");

        // Reset at byte 10 of primitive 1, then a clean single dump.
        base = hs_total;
        run_dump(2, 1'b0);
        k = 0;
        while (hs_total < base + PB + 10 && k < 2000) begin @(posedge clk); #1; k++; end
        reset = 1'b1;
        bq.delete(); rdq.delete(); dq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs_zero("midreset");
        run_dump(1, 1'b1);
        wait_idle("after_reset");

        // Full address range: count of 2**AW must not wrap.
        fill_random(1 << AW);
        run_dump(1 << AW, 1'b1);
        wait_idle("full_range");

        // Random counts and back-pressure.
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 5);
            fill_random(n);
            ready_mode = it % 2;
            run_dump(n, ready_mode == 0);
            wait_idle("random");
        end
        ready_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prim_dump_tx.md
Name: prim_dump_tx

Overview:
- Streams primitive records out of the primitive RAM as a byte stream, for host-side checking and scene round-trips.
- This is the write-out counterpart of loading primitive records from a hex image.
- Walks primitive indices 0..NUM_PRIMS-1, reads each packed Primitive_AABB word, and serializes it MSB-first onto a valid/ready byte interface.
- Sits between the primitive BRAM (second read port) and the debug UART/USB transmitter.

Parameters:
PRIM_ADDR_WIDTH, 8, primitive index/address width.
FIXED_WIDTH, 32, width of one Fixed value.
COLOR_WIDTH, 8, width of one colour channel.
PRIM_WIDTH, 6*FIXED_WIDTH+3*COLOR_WIDTH (216), packed primitive width; must be a multiple of 8.
PRIM_BYTES, PRIM_WIDTH/8 (27), bytes per primitive.

Ports:
CLK  in  1  system clock.
RESET  in  1  synchronous, active-high reset.
START  in  1  one-cycle pulse; begins a dump when idle.
NUM_PRIMS  in  PRIM_ADDR_WIDTH+1  number of primitives to dump; sampled on accepted START.
BUSY  out  1  high from accepted START until DONE.
DONE  out  1  one-cycle pulse when the dump completes.
MEM_RD_EN  out  1  primitive RAM read enable.
MEM_ADDR  out  PRIM_ADDR_WIDTH  primitive RAM read address.
MEM_DATA  in  PRIM_WIDTH  RAM read data, valid exactly 1 cycle after MEM_RD_EN.
TX_DATA  out  8  output byte.
TX_VALID  out  1  TX_DATA valid.
TX_READY  in  1  sink accepts the byte when TX_VALID && TX_READY.
TX_LAST  out  1  high with the final byte of the final primitive.

Behaviour:
- Interface: one clock, CLK; reset RESET is synchronous and active-high.
- Reset values: BUSY=0, DONE=0, MEM_RD_EN=0, MEM_ADDR=0, TX_VALID=0, TX_LAST=0, TX_DATA=0. All outputs are registered.
- Reset asserted mid-dump: the state returns to IDLE, and TX_VALID/BUSY read 0 in the cycle after RESET is sampled. No DONE pulse.
- Packing, MSB first, matching field order in the hex image:
  - [215:120] Min X,Y,Z
  - [119:24] Max X,Y,Z
  - [23:0] Color Channel[0],[1],[2]
  - Byte 0 sent = MEM_DATA[215:208]; byte 26 = MEM_DATA[7:0].
- States:
  - IDLE: wait for START.
    - START with NUM_PRIMS==0 -> DONE pulses the next cycle, BUSY stays 0, no RAM reads, no bytes sent.
    - START with NUM_PRIMS>0 -> latch count, idx=0, BUSY=1, go to FETCH.
  - FETCH (1 cycle): MEM_RD_EN=1, MEM_ADDR=idx; go to WAIT.
  - WAIT (1 cycle): capture MEM_DATA into the shift register, byte counter=0; go to SEND.
  - SEND:
    - TX_VALID=1 and TX_DATA = top byte of the shift register.
    - On handshake: shift left 8 and increment the byte counter.
    - Handshake on byte PRIM_BYTES-1:
      - If idx==count-1 -> go to FIN.
      - Otherwise idx++ and go to FETCH.
  - FIN (1 cycle): DONE=1, BUSY=0, return to IDLE.
- Handshake rules:
  - While TX_VALID=1 and TX_READY=0, TX_DATA and TX_LAST hold stable.
  - TX_VALID never drops without a handshake, except on reset.
  - Back-to-back handshakes run one byte per cycle.
- Latency and timing:
  - START accepted at cycle 0 -> MEM_RD_EN at cycle 1 -> first TX_VALID at cycle 3.
  - Between primitives TX_VALID is low for exactly 2 cycles (FETCH, WAIT).
  - DONE occurs 1 cycle after the final handshake.
- TX_LAST is 1 only while presenting byte PRIM_BYTES-1 of primitive count-1.
- START while BUSY is ignored; NUM_PRIMS changes while BUSY are ignored.
- Count range: NUM_PRIMS up to 2**PRIM_ADDR_WIDTH is legal; the idx compare uses PRIM_ADDR_WIDTH+1 bits, so there is no wrap.
- MEM_ADDR holds its last value when not reading; MEM_RD_EN is a single-cycle pulse per primitive.
- Total bytes per dump = NUM_PRIMS*PRIM_BYTES. Exactly NUM_PRIMS RAM reads occur, at ascending addresses.

Test Plan:
- RAM[0]={Min(1.0,2.0,3.0)=0x00010000,0x00020000,0x00030000; Max(4.0,5.0,6.0); Color 0xFF,0x80,0x01}, NUM_PRIMS=1, TX_READY=1 -> 27 consecutive bytes 00 01 00 00 00 02 ... FF 80 01. First TX_VALID 3 cycles after START; TX_LAST on byte 27 only; DONE 1 cycle later.
- NUM_PRIMS=4 with distinct patterns (RAM[i] bytes = i in every position), TX_READY=1 -> 108 bytes, 2-cycle TX_VALID gaps at bytes 27/54/81, reads at addresses 0,1,2,3, single DONE.
- NUM_PRIMS=2, TX_READY random 30% duty -> byte sequence identical to the full-rate case, and TX_DATA stable whenever VALID && !READY.
- NUM_PRIMS=0 -> DONE one cycle after START, BUSY never high, no MEM_RD_EN, no TX_VALID.
- START re-pulsed mid-dump with NUM_PRIMS=7 -> ignored; the original count completes.
- RESET asserted at byte 10 of primitive 1 -> all outputs 0 next cycle; a following START with NUM_PRIMS=1 dumps cleanly from address 0.
